sipo_rx: RTL and testbench

- Serial-to-parallel receiver: the receive end of the team's parallel-load serial shifter link.
- Collects WIDTH serial bits, qualified by a bit strobe, in MSB-first or LSB-first order.
- Presents the assembled word on a registered parallel output with a valid/ready handshake and overrun detection.
- Sits between a serial line/pin synchroniser and the consuming datapath.

---
 rtl/sipo_pkg.sv | 27 ++
 rtl/sipo_bitcnt.sv | 35 +++
 rtl/sipo_rx.sv | 141 ++++++++++++++
 tb/tb_sipo_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants for the serial-to-parallel receiver (sipo_rx).
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Optional feature macro: SIPO_RX_PARITY_EN adds one even-parity bit per frame.
package sipo_pkg;

  // Bit-order selector values for the dir input.
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Default data word width.
  localparam int SIPO_WIDTH = 8;

  // Number of strobed bits appended to the data bits in every frame.
`ifdef SIPO_RX_PARITY_EN
  localparam int SIPO_PAR_BITS = 1;
`else
  localparam int SIPO_PAR_BITS = 0;
`endif

  // Total strobed bits per frame for a given data width.
  function automatic int sipo_frame_len(input int width);
    return width + SIPO_PAR_BITS;
  endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Frame bit counter: counts strobed bits, wraps to 0 after the terminal bit.
// Latency: count updates on the strobe edge; last is combinational from count.
// Backpressure: none; inc advances unconditionally, clr wins over inc.
//
// Ports:
//   clk, rstn   clock and asynchronous active-high reset
//   clr         synchronous clear of the count
//   inc         advance by one bit (wraps to 0 when last is high)
//   count       current number of bits received in this frame
//   last        the next inc completes the frame
module sipo_bitcnt #(
  parameter int TERM  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = (count == CNT_W'(TERM - 1));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: assembles WIDTH strobed bits (MSB- or LSB-first) into a word.
// Latency: dout/dout_valid are valid the cycle after the edge sampling the final frame bit.
// Backpressure: dout_ready only drains dout_valid; a new word overwrites an unaccepted one and sets overrun.
//
// Ports:
//   clk, rstn      clock and asynchronous active-high reset
//   clr            synchronous abort of the partial word (output register untouched)
//   bit_en, din    bit strobe and serial data bit
//   dir            0 = MSB-first, 1 = LSB-first; sampled with the first bit of a frame only
//   dout           assembled word, held until the next completion
//   dout_valid     word available; cleared by dout_ready
//   dout_ready     consumer accepts the word
//   busy           a frame is partially received
//   overrun        sticky: a completion replaced an unaccepted word
//   ovr_clr        clears overrun (a simultaneous new overrun wins)
//   parity_err     (SIPO_RX_PARITY_EN only) even-parity check result of the last frame
//
// Optional feature macro: SIPO_RX_PARITY_EN.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             din,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
`ifdef SIPO_RX_PARITY_EN
  output logic             parity_err,
`endif
  input  logic             ovr_clr
);

  localparam int FRAME = sipo_frame_len(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] count;
  logic             last;
  logic             first;
  logic             dir_lat;
  logic             dir_eff;
  logic             take;
  logic             shift_en;
  logic             done;

  sipo_bitcnt #(
    .TERM  (FRAME),
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .inc   (take),
    .count (count),
    .last  (last)
  );

  assign first = (count == '0);
  assign busy  = !first;
  assign take  = bit_en && !clr;
  assign done  = take && last;

  // The first bit of a frame must already follow the newly requested order,
  // so the live dir input is used until dir_lat has captured it.
  assign dir_eff = first ? dir : dir_lat;

  assign sr_nxt = (dir_eff == DIR_LSB_FIRST) ? {din, sr[WIDTH-1:1]}
                                             : {sr[WIDTH-2:0], din};

  always_comb begin
    shift_en = take;
    word     = sr_nxt;
`ifdef SIPO_RX_PARITY_EN
    // The parity bit is the final strobe; it is checked, never shifted in.
    shift_en = take && !last;
    word     = sr;
`endif
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sr      <= '0;
      dir_lat <= DIR_MSB_FIRST;
    end else if (clr) begin
      sr <= '0;
    end else begin
      if (take && first) begin
        dir_lat <= dir;
      end
      if (shift_en) begin
        sr <= sr_nxt;
      end
    end
  end

  // A completion always loads the output; an accept on the same edge is
  // absorbed by the new word, which keeps dout_valid high.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (done) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      parity_err <= 1'b0;
    end else if (done) begin
      parity_err <= (^sr) ^ din;
    end
  end
`endif

  // Setting beats clearing so a same-edge overrun is never lost.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      overrun <= 1'b0;
    end else if (done && dout_valid && !dout_ready) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx: directed cases followed by random strobes, checked
// against a frame-level reference model (bit list -> word by position arithmetic).
module tb_sipo_rx;
  import sipo_pkg::*;

  localparam int W     = SIPO_WIDTH;
  localparam int FRAME = W + SIPO_PAR_BITS;

  logic         clk = 1'b0;
  logic         rstn;
  logic         clr;
  logic         bit_en;
  logic         din;
  logic         dir;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         overrun;
  logic         ovr_clr;
`ifdef SIPO_RX_PARITY_EN
  logic         parity_err;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  bit           q[$];
  bit           m_dir;
  logic [W-1:0] m_dout;
  bit           m_valid;
  bit           m_ovr;
  bit           m_perr;

  sipo_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .bit_en     (bit_en),
    .din        (din),
    .dir        (dir),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun),
`ifdef SIPO_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dir   = 1'b0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},    32'(dout),       32'(m_dout));
    chk({tag, ".valid"},   32'(dout_valid), 32'(m_valid));
    chk({tag, ".busy"},    32'(busy),       32'(q.size() != 0));
    chk({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
`ifdef SIPO_RX_PARITY_EN
    chk({tag, ".perr"},    32'(parity_err), 32'(m_perr));
`endif
  endtask

  // Frame-level model: collect strobed bits; at FRAME bits place bit i at
  // position W-1-i (MSB-first) or i (LSB-first), parity = XOR of all bits.
  task automatic model_edge(input bit c, input bit be, input bit d, input bit dr,
                            input bit rdy, input bit oc);
    bit           done = 1'b0;
    bit           par  = 1'b0;
    logic [W-1:0] wd   = '0;
    if (c) begin
      q.delete();
    end else if (be) begin
      if (q.size() == 0) m_dir = dr;
      q.push_back(d);
      if (q.size() == FRAME) begin
        for (int i = 0; i < W; i++) wd[m_dir ? i : W - 1 - i] = q[i];
        foreach (q[i]) par ^= q[i];
        done = 1'b1;
        q.delete();
      end
    end
    if (done && m_valid && !rdy) m_ovr = 1'b1;
    else if (oc)                 m_ovr = 1'b0;
    if (done) begin
      m_dout  = wd;
      m_valid = 1'b1;
      m_perr  = par;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 ns later.
  task automatic cyc(input bit c, input bit be, input bit d, input bit dr,
                     input bit rdy, input bit oc, input string tag);
    clr = c; bit_en = be; din = d; dir = dr; dout_ready = rdy; ovr_clr = oc;
    @(posedge clk);
    model_edge(c, be, d, dr, rdy, oc);
    #1;
    check_model(tag);
  endtask

  // Send one frame; seq[7] goes first. rdy_last/oc_last apply to the final strobe.
  task automatic send(input logic [7:0] seq, input bit dr, input bit rdy_body,
                      input bit rdy_last, input bit oc_last, input bit toggle,
                      input bit parbit, input string tag);
    for (int i = 0; i < W; i++) begin
      bit is_last = (FRAME == W) && (i == W - 1);
      cyc(1'b0, 1'b1, seq[7-i], toggle ? (dr ^ i[0]) : dr,
          is_last ? rdy_last : rdy_body, is_last ? oc_last : 1'b0, tag);
    end
`ifdef SIPO_RX_PARITY_EN
    cyc(1'b0, 1'b1, parbit, dr, rdy_last, oc_last, tag);
`else
    if (parbit) begin end
`endif
  endtask

  initial begin
    rstn = 1'b1; clr = 1'b0; bit_en = 1'b0; din = 1'b0; dir = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0;
    model_reset();
    #2;
    chk("rst.dout",    32'(dout),       32'h0);
    chk("rst.valid",   32'(dout_valid), 32'h0);
    chk("rst.busy",    32'(busy),       32'h0);
    chk("rst.overrun", 32'(overrun),    32'h0);
    @(negedge clk);
    rstn = 1'b0;

    // MSB-first 0x12, then accept.
    send(8'b0001_0010, DIR_MSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "msb");
    chk("msb.word",  32'(dout),       32'h12);
    chk("msb.valid", 32'(dout_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "msb_acc");
    chk("msb_acc.valid", 32'(dout_valid), 32'h0);
    chk("msb_acc.hold",  32'(dout),       32'h12);

    // LSB-first, plain and with dir toggling mid-word.
    send(8'b0001_0010, DIR_LSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lsb");
    chk("lsb.word", 32'(dout), 32'h48);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lsb_acc");
    send(8'b0001_0010, DIR_LSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "tog");
    chk("tog.word", 32'(dout), 32'h48);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "tog_acc");

    // Overrun, clear, then set-beats-clear.
    send(8'hA5, DIR_MSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ovr1");
    send(8'h3C, DIR_MSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ovr2");
    chk("ovr.word", 32'(dout),    32'h3C);
    chk("ovr.flag", 32'(overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clr");
    chk("ovr_clr.flag", 32'(overrun), 32'h0);
    send(8'h5A, DIR_MSB_FIRST, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ovr_win");
    chk("ovr_win.flag", 32'(overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clr2");

    // Completion on the same edge as accepting the previous word.
    send(8'hC3, DIR_MSB_FIRST, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "same");
    chk("same.word",  32'(dout),       32'hC3);
    chk("same.valid", 32'(dout_valid), 32'h1);
    chk("same.ovr",   32'(overrun),    32'h0);

    // clr together with the 5th bit, then a fresh word.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "pre_clr");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "clr5");
    chk("clr5.busy", 32'(busy), 32'h0);
    send(8'h96, DIR_MSB_FIRST, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "after_clr");
    chk("after_clr.word", 32'(dout), 32'h96);

    // Async reset mid-word with valid and overrun set.
    send(8'h11, DIR_MSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst_bits");
    #2;
    rstn = 1'b1;
    #1;
    chk("arst.dout",    32'(dout),       32'h0);
    chk("arst.valid",   32'(dout_valid), 32'h0);
    chk("arst.busy",    32'(busy),       32'h0);
    chk("arst.overrun", 32'(overrun),    32'h0);
    model_reset();
    @(negedge clk);
    rstn = 1'b0;
    send(8'hFF, DIR_LSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ff");
    chk("ff.word", 32'(dout), 32'hFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ff_acc");

`ifdef SIPO_RX_PARITY_EN
    send(8'h12, DIR_MSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "par0");
    chk("par0.word", 32'(dout),       32'h12);
    chk("par0.err",  32'(parity_err), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "par0_acc");
    send(8'h12, DIR_MSB_FIRST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "par1");
    chk("par1.word", 32'(dout),       32'h12);
    chk("par1.err",  32'(parity_err), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "par1_acc");
`endif

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, 1'($urandom),
          1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
